// File: rtl/clk_enable_gen.sv
// rtl/clk_enable_gen.sv - multi-channel programmable clock-enable generator
module clk_enable_gen #(
  parameter int                          NUM_CH  = 3,
  parameter int                          CNT_W   = 26,
  parameter int                          CH_W    = 3,
  parameter logic [NUM_CH*CNT_W-1:0]     RST_DIV = {26'd16777216, 26'd1024, 26'd8}
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NUM_CH-1:0] EN,
  input  logic              SYNC,
  input  logic              WR_EN,
  input  logic [CH_W-1:0]   WR_CH,
  input  logic [CNT_W-1:0]  WR_DIV,
  output logic [NUM_CH-1:0] TICK,
  output logic [NUM_CH-1:0] SQW
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tick_q;
    logic             sqw_q;
    logic [CNT_W-1:0] last_cnt;
    logic             wr_sel;

    // DIV of 0 or 1 both collapse to divide-by-1, so the terminal count is 0.
    assign last_cnt = (div_q < CNT_W'(2)) ? '0 : div_q - CNT_W'(1);
    assign wr_sel   = WR_EN && (WR_CH == CH_W'(i));

    always_ff @(posedge CLK) begin
      if (RST) begin
        div_q  <= RST_DIV[i*CNT_W +: CNT_W];
        cnt_q  <= '0;
        tick_q <= 1'b0;
        sqw_q  <= 1'b0;
      end else begin
        if (wr_sel)
          div_q <= WR_DIV;
        if (SYNC) begin
          cnt_q  <= '0;
          tick_q <= 1'b0;
          sqw_q  <= 1'b0;
        end else if (wr_sel) begin
          cnt_q  <= '0;
          tick_q <= 1'b0;
        end else if (EN[i]) begin
          if (cnt_q == last_cnt) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
            sqw_q  <= ~sqw_q;
          end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
            tick_q <= 1'b0;
          end
        end else begin
          tick_q <= 1'b0;
        end
      end
    end

    assign TICK[i] = tick_q;
    assign SQW[i]  = sqw_q;
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// tb/tb_clk_enable_gen.sv - scoreboard bench for clk_enable_gen
module tb_clk_enable_gen;
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 26;
  localparam int CH_W   = 3;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [NUM_CH-1:0] EN = '0;
  logic              SYNC = 1'b0;
  logic              WR_EN = 1'b0;
  logic [CH_W-1:0]   WR_CH = '0;
  logic [CNT_W-1:0]  WR_DIV = '0;
  logic [NUM_CH-1:0] TICK;
  logic [NUM_CH-1:0] SQW;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [2*NUM_CH-1:0] exp_q[$];

  int mdiv [NUM_CH];
  int mcnt [NUM_CH];
  logic [NUM_CH-1:0] mtick, msqw;
  int rst_div [NUM_CH] = '{8, 1024, 16777216};

  clk_enable_gen dut (
    .CLK(CLK), .RST(RST), .EN(EN), .SYNC(SYNC), .WR_EN(WR_EN),
    .WR_CH(WR_CH), .WR_DIV(WR_DIV), .TICK(TICK), .SQW(SQW)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: advance the count first, then wrap when it reaches D.
  task automatic model_edge();
    for (int i = 0; i < NUM_CH; i++) begin
      bit w;
      int d;
      if (RST) begin
        mdiv[i] = rst_div[i]; mcnt[i] = 0; mtick[i] = 0; msqw[i] = 0;
      end else begin
        w = WR_EN && (int'(WR_CH) == i);
        if (SYNC) begin
          mcnt[i] = 0; mtick[i] = 0; msqw[i] = 0;
        end else if (w) begin
          mcnt[i] = 0; mtick[i] = 0;
        end else if (EN[i]) begin
          d = (mdiv[i] < 2) ? 1 : mdiv[i];
          mcnt[i] = mcnt[i] + 1;
          if (mcnt[i] == d) begin
            mcnt[i] = 0; mtick[i] = 1; msqw[i] = ~msqw[i];
          end else begin
            mtick[i] = 0;
          end
        end else begin
          mtick[i] = 0;
        end
        if (w) mdiv[i] = int'(WR_DIV);
      end
    end
    exp_q.push_back({mtick, msqw});
  endtask

  task automatic step(input logic rst, input logic [NUM_CH-1:0] en, input logic sync,
                      input logic wr_en, input logic [CH_W-1:0] wr_ch, input logic [CNT_W-1:0] wr_div);
    @(negedge CLK);
    RST = rst; EN = en; SYNC = sync; WR_EN = wr_en; WR_CH = wr_ch; WR_DIV = wr_div;
    model_edge();
  endtask

  task automatic run(input logic [NUM_CH-1:0] en);
    step(1'b0, en, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic sample();
    @(posedge CLK);
    #2;
  endtask

  // Monitor: every edge that had stimulus behind it presents a full output word.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        logic [2*NUM_CH-1:0] e;
        e = exp_q.pop_front();
        check("sb_tick_sqw", {TICK, SQW}, e);
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) step(1'b1, '0, 1'b0, 1'b0, '0, '0);
    sample();
    check("reset_tick", TICK, 0);
    check("reset_sqw", SQW, 0);

    // 1: reset defaults, ch0 divides by 8
    for (int c = 1; c <= 40; c++) begin
      run(3'b111);
      sample();
      check("t1_tick0", TICK[0], (c % 8 == 0));
      check("t1_sqw0", SQW[0], (c / 8) % 2);
      check("t1_tick12", TICK[2:1], 0);
    end

    // 2: reload mid-count (CNT0=3), then divide-by-0 and divide-by-1
    for (int c = 0; c < 3; c++) run(3'b111);
    step(1'b0, 3'b111, 1'b0, 1'b1, 3'd0, 26'd5);
    sample();
    check("t2_wr_clears", TICK[0], 0);
    for (int k = 1; k <= 12; k++) begin
      run(3'b111); sample();
      check("t2_div5", TICK[0], (k % 5 == 0));
    end
    step(1'b0, 3'b111, 1'b0, 1'b1, 3'd0, 26'd0);
    sample();
    check("t2_div0_wr", TICK[0], 0);
    for (int k = 1; k <= 4; k++) begin
      run(3'b111); sample();
      check("t2_div0", TICK[0], 1);
    end
    step(1'b0, 3'b111, 1'b0, 1'b1, 3'd0, 26'd1);
    sample();
    check("t2_div1_wr", TICK[0], 0);
    for (int k = 1; k <= 4; k++) begin
      run(3'b111); sample();
      check("t2_div1", TICK[0], 1);
    end

    // 3: divide 4, pause EN[0] at CNT0=2
    step(1'b0, 3'b111, 1'b0, 1'b1, 3'd0, 26'd4);
    for (int k = 1; k <= 2; k++) begin
      run(3'b111); sample();
      check("t3_pre", TICK[0], 0);
    end
    for (int k = 1; k <= 3; k++) begin
      run(3'b110); sample();
      check("t3_paused", TICK[0], 0);
    end
    run(3'b111); sample();
    check("t3_resume1", TICK[0], 0);
    run(3'b111); sample();
    check("t3_resume2", TICK[0], 1);

    // 4: ch0=3, ch1=7, SYNC aligns them
    step(1'b0, 3'b111, 1'b0, 1'b1, 3'd0, 26'd3);
    step(1'b0, 3'b111, 1'b0, 1'b1, 3'd1, 26'd7);
    for (int k = 0; k < 5; k++) run(3'b111);
    step(1'b0, 3'b111, 1'b1, 1'b0, '0, '0);
    sample();
    check("t4_sync_tick", TICK, 0);
    check("t4_sync_sqw", SQW, 0);
    // 5: out-of-range write at k=22 must not disturb the pattern
    for (int k = 1; k <= 42; k++) begin
      if (k == 22) step(1'b0, 3'b111, 1'b0, 1'b1, 3'd5, 26'd1);
      else run(3'b111);
      sample();
      check("t45_tick0", TICK[0], (k % 3 == 0));
      check("t45_tick1", TICK[1], (k % 7 == 0));
    end

    // 6: reset beats simultaneous SYNC and write
    for (int k = 0; k < 5; k++) run(3'b111);
    step(1'b1, 3'b111, 1'b1, 1'b1, 3'd0, 26'd5);
    sample();
    check("t6_rst_tick", TICK, 0);
    check("t6_rst_sqw", SQW, 0);
    for (int c = 1; c <= 16; c++) begin
      run(3'b111); sample();
      check("t6_tick0", TICK[0], (c % 8 == 0));
      check("t6_tick1", TICK[1], 0);
    end

    // Random traffic against the reference model
    for (int n = 0; n < 10000; n++) begin
      logic r, s, w;
      logic [CNT_W-1:0] dv;
      r  = ($urandom_range(499) == 0);
      s  = ($urandom_range(49) == 0);
      w  = ($urandom_range(9) == 0);
      dv = ($urandom_range(99) == 0) ? {CNT_W{1'b1}} : CNT_W'($urandom_range(12));
      step(r, NUM_CH'($urandom_range(7)), s, w, CH_W'($urandom_range(7)), dv);
    end

    sample();
    sample();
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
